dropout_backward_mask: RTL and testbench
========================================

# dropout_backward_mask

Backward-pass companion to the 8-neuron random dropout stage. During the forward pass it records, per sample, the 8-bit keep mask the dropout stage applied. During the backward pass it replays those masks in reverse order (LIFO), so each incoming gradient is masked exactly as its activation was. It sits between the upstream gradient source and the previous layer's gradient input, and is fed the forward mask alongside the dropout output.

## Interface

- `DEPTH`, 16 — maximum number of stored masks (samples per batch).
- `WIDTH`, 8 — neurons per sample; one mask bit and one gradient bit per neuron.

- `clk` in 1 — single clock; all state updates on the rising edge.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `ui_ena` in 1 — block enable; when low, no new mask push and no new gradient accept.
- `fwd_valid` in 1 — forward mask present.
- `fwd_mask` in WIDTH — applied keep mask; 1 = neuron kept.
- `fwd_ready` out 1 — mask accepted when `fwd_valid & fwd_ready`.
- `bwd_start` in 1 — single-cycle pulse that ends recording and begins replay.
- `grad_in_valid` in 1, `grad_in` in WIDTH, `grad_in_ready` out 1 — gradient input handshake.
- `grad_out_valid` out 1, `grad_out` out WIDTH, `grad_out_ready` in 1 — masked gradient output handshake.
- `count` out $clog2(DEPTH)+1 — number of stored masks.
- `err` out 1 — sticky protocol-error flag, cleared only by reset.

## Operation

- **Storage.** DEPTH×WIDTH register stack with pointer `count`.
- **States.** REC (reset state) and REPLAY.
- **REC, ready.** `fwd_ready = ui_ena & (count < DEPTH)`.
- **REC, push.** On a push, `stack[count] <= fwd_mask` and `count+1`.
- **REC, gradient.** `grad_in_ready = 0`.
- **REC, `bwd_start`.**
  - If `count > 0` after this cycle's push, go to REPLAY next cycle.
  - If `count == 0`, stay in REC and set `err`.
  - A push and `bwd_start` in the same cycle: the push completes first, then the transition occurs.
- **REPLAY, forward path.** `fwd_ready = 0`. `fwd_valid` high sets `err`; the mask is dropped. `bwd_start` is ignored.
- **REPLAY, gradient ready.** `grad_in_ready = ui_ena & (count > 0) & (~grad_out_valid | grad_out_ready)`.
- **REPLAY, pop.** On accept:
  - `grad_out <= grad_in & stack[count-1]`
  - `grad_out_valid <= 1`
  - `count` decrements.
- **Output register.** `grad_out_valid` clears on `grad_out_ready` when no new accept occurs that cycle. `grad_out` and `grad_out_valid` are stable while valid and not ready.
- **REPLAY → REC.** When `count == 0` and the output register is empty, or is being drained this cycle, the next state is REC.
- **`ui_ena` low.**
  - Blocks pushes and gradient accepts.
  - A pending `grad_out` may still be consumed.
  - State, `count` and `err` are held except for that drain.
- **Full (`count == DEPTH`).** `fwd_ready = 0`. `fwd_valid` is not an error; the upstream stalls.
- **Reset mid-operation.** All stored masks are discarded; the block returns to REC with `count = 0`.

## Timing

- **Reset values.**
  - state REC, `count = 0`, `grad_out = 0`, `grad_out_valid = 0`, `err = 0`.
  - Stack contents are don't-care.
  - `fwd_ready` = `ui_ena` combinationally; `grad_in_ready` = 0.
- **Latency.** `grad_in` accepted at edge N appears on `grad_out` with `grad_out_valid = 1` after edge N.
- **Throughput.** One gradient per cycle when `grad_out_ready` is held high.
- **Push visibility.** `count` updates at the edge of the push.
- **Start visibility.** The first REPLAY cycle is the cycle after the `bwd_start` edge.
- **`err`.** Registered; rises the cycle after the offending event.

## Test plan

1. **Basic replay.** Push masks 0xFF, 0x0F, 0xA5; pulse `bwd_start`; send `grad_in` 0xFF three times with `grad_out_ready = 1`.
   - Expect `grad_out` 0xA5, 0x0F, 0xFF on consecutive cycles, each one cycle after accept.
   - Expect `count` 3→0, then REC (`fwd_ready = 1`).
2. **Full.** Push 16 masks, then hold `fwd_valid` high.
   - Expect `fwd_ready = 0`, `count = 16`, `err = 0`.
   - Replay 16 gradients of 0x3C: each `grad_out` equals 0x3C & the matching mask, in reverse order.
3. **Backpressure.** In REPLAY, hold `grad_out_ready = 0` after one accept.
   - Expect `grad_in_ready = 0` and `grad_out` held stable until ready.
   - Then release; no data is lost or duplicated.
4. **Errors.**
   - `bwd_start` with `count = 0` → `err = 1` next cycle, state stays REC.
   - `fwd_valid` during REPLAY → `err = 1`, `count` unchanged.
5. **Simultaneous and enable.**
   - Push with `bwd_start` in the same cycle and `count = 0` → `count = 1`, REPLAY, `err = 0`.
   - `ui_ena = 0` in REPLAY → no accepts, `count` held.
6. **Reset mid-replay.** Assert `rst_n` low with `count = 2` and `grad_out_valid = 1`.
   - Expect immediate `count = 0`, `grad_out_valid = 0`, state REC.

Source files
------------

// File: rtl/dropout_backward_mask.sv
// Records per-sample dropout keep masks during the forward pass and replays them
// LIFO to mask incoming gradients during the backward pass.
module dropout_backward_mask #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ui_ena,
    input  logic                   fwd_valid,
    input  logic [WIDTH-1:0]       fwd_mask,
    output logic                   fwd_ready,
    input  logic                   bwd_start,
    input  logic                   grad_in_valid,
    input  logic [WIDTH-1:0]       grad_in,
    output logic                   grad_in_ready,
    output logic                   grad_out_valid,
    output logic [WIDTH-1:0]       grad_out,
    input  logic                   grad_out_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    typedef enum logic [0:0] {REC = 1'b0, REPLAY = 1'b1} state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CW-1:0]     count_r;
    logic [CW-1:0]     count_nxt_s;
    logic              err_r;
    logic              err_nxt_s;
    logic [WIDTH-1:0]  stack_r [DEPTH];
    logic [WIDTH-1:0]  grad_out_r;
    logic              grad_out_valid_r;
    logic [CW-1:0]     pop_idx_s;
    logic              push_s;
    logic              accept_s;

    assign pop_idx_s     = count_r - ONE_C;
    assign fwd_ready     = (state_r == REC) && ui_ena && (count_r < DEPTH_C);
    assign grad_in_ready = (state_r == REPLAY) && ui_ena && (count_r != ZERO_C) &&
                           (!grad_out_valid_r || grad_out_ready);
    assign push_s        = fwd_valid && fwd_ready;
    assign accept_s      = grad_in_valid && grad_in_ready;

    assign count          = count_r;
    assign err            = err_r;
    assign grad_out       = grad_out_r;
    assign grad_out_valid = grad_out_valid_r;

    // Next-state, stack pointer and error decisions for both phases.
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        err_nxt_s   = err_r;
        case (state_r)
            REC: begin
                if (push_s) begin
                    count_nxt_s = count_r + ONE_C;
                end else begin
                    count_nxt_s = count_r;
                end
                // The same-cycle push counts toward the non-empty check.
                if (ui_ena && bwd_start) begin
                    if (count_nxt_s != ZERO_C) begin
                        state_nxt_s = REPLAY;
                    end else begin
                        err_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = REC;
                end
            end
            REPLAY: begin
                if (accept_s) begin
                    count_nxt_s = count_r - ONE_C;
                end else begin
                    count_nxt_s = count_r;
                end
                if (ui_ena && fwd_valid) begin
                    err_nxt_s = 1'b1;
                end else begin
                    err_nxt_s = err_r;
                end
                if ((count_r == ZERO_C) && (!grad_out_valid_r || grad_out_ready)) begin
                    state_nxt_s = REC;
                end else begin
                    state_nxt_s = REPLAY;
                end
            end
            default: begin
                state_nxt_s = REC;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= REC;
            count_r <= ZERO_C;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    // Mask stack; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            stack_r[count_r[CW-2:0]] <= fwd_mask;
        end
    end

    // Masked gradient output register with valid/ready hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grad_out_r       <= {WIDTH{1'b0}};
            grad_out_valid_r <= 1'b0;
        end else if (accept_s) begin
            grad_out_r       <= grad_in & stack_r[pop_idx_s[CW-2:0]];
            grad_out_valid_r <= 1'b1;
        end else if (grad_out_ready) begin
            grad_out_valid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dropout_backward_mask.sv
// Directed self-checking bench for dropout_backward_mask with hand-computed expectations.
module tb_dropout_backward_mask;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ui_ena;
    logic       fwd_valid;
    logic [7:0] fwd_mask;
    logic       fwd_ready;
    logic       bwd_start;
    logic       grad_in_valid;
    logic [7:0] grad_in;
    logic       grad_in_ready;
    logic       grad_out_valid;
    logic [7:0] grad_out;
    logic       grad_out_ready;
    logic [4:0] count;
    logic       err;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    logic [7:0] masks [16];

    dropout_backward_mask #(.DEPTH(16), .WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .ui_ena(ui_ena),
        .fwd_valid(fwd_valid), .fwd_mask(fwd_mask), .fwd_ready(fwd_ready),
        .bwd_start(bwd_start),
        .grad_in_valid(grad_in_valid), .grad_in(grad_in), .grad_in_ready(grad_in_ready),
        .grad_out_valid(grad_out_valid), .grad_out(grad_out), .grad_out_ready(grad_out_ready),
        .count(count), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miss_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] m);
        fwd_valid = 1'b1;
        fwd_mask  = m;
        tick();
        fwd_valid = 1'b0;
    endtask

    task automatic start();
        bwd_start = 1'b1;
        tick();
        bwd_start = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; ui_ena = 1'b0; fwd_valid = 1'b0; fwd_mask = 8'h00;
        bwd_start = 1'b0; grad_in_valid = 1'b0; grad_in = 8'h00; grad_out_ready = 1'b0;
        #2;
        chk("rst_count", count, 32'd0);
        chk("rst_gov", grad_out_valid, 32'd0);
        chk("rst_gout", grad_out, 32'h0);
        chk("rst_err", err, 32'd0);
        chk("rst_fwd_ready_ena0", fwd_ready, 32'd0);
        ui_ena = 1'b1;
        #1;
        chk("rst_fwd_ready_ena1", fwd_ready, 32'd1);
        chk("rst_gin_ready", grad_in_ready, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1. basic replay
        push(8'hFF); chk("t1_count1", count, 32'd1);
        push(8'h0F); chk("t1_count2", count, 32'd2);
        push(8'hA5); chk("t1_count3", count, 32'd3);
        start();
        chk("t1_replay_fwd_ready", fwd_ready, 32'd0);
        chk("t1_count_start", count, 32'd3);
        grad_in_valid = 1'b1; grad_in = 8'hFF; grad_out_ready = 1'b1;
        #1;
        chk("t1_gin_ready", grad_in_ready, 32'd1);
        tick();
        chk("t1_out0", grad_out, 32'hA5); chk("t1_gov0", grad_out_valid, 32'd1); chk("t1_cnt0", count, 32'd2);
        tick();
        chk("t1_out1", grad_out, 32'h0F); chk("t1_cnt1", count, 32'd1);
        tick();
        chk("t1_out2", grad_out, 32'hFF); chk("t1_cnt2", count, 32'd0);
        grad_in_valid = 1'b0;
        #1;
        chk("t1_gin_ready_empty", grad_in_ready, 32'd0);
        tick();
        chk("t1_drained", grad_out_valid, 32'd0);
        chk("t1_back_rec", fwd_ready, 32'd1);

        // 2. full stack
        for (int i = 0; i < 16; i++) begin
            masks[i] = 8'(i * 37 + 3);
            push(masks[i]);
        end
        fwd_valid = 1'b1; fwd_mask = 8'h77;
        #1;
        chk("t2_full_ready", fwd_ready, 32'd0);
        chk("t2_full_count", count, 32'd16);
        tick();
        chk("t2_full_count_hold", count, 32'd16);
        chk("t2_full_err", err, 32'd0);
        fwd_valid = 1'b0;
        start();
        grad_in_valid = 1'b1; grad_in = 8'h3C; grad_out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            chk($sformatf("t2_out%0d", k), grad_out, {24'h0, 8'h3C & masks[15-k]});
        end
        grad_in_valid = 1'b0;
        tick();
        chk("t2_count0", count, 32'd0);
        chk("t2_back_rec", fwd_ready, 32'd1);

        // 3. backpressure
        push(8'h81); push(8'h7E); start();
        grad_in_valid = 1'b1; grad_in = 8'hFF; grad_out_ready = 1'b0;
        tick();
        chk("t3_out_first", grad_out, 32'h7E);
        chk("t3_gin_ready_bp", grad_in_ready, 32'd0);
        tick(); tick();
        chk("t3_out_held", grad_out, 32'h7E);
        chk("t3_gov_held", grad_out_valid, 32'd1);
        chk("t3_count_held", count, 32'd1);
        grad_out_ready = 1'b1;
        #1;
        chk("t3_gin_ready_rel", grad_in_ready, 32'd1);
        tick();
        chk("t3_out_second", grad_out, 32'h81);
        chk("t3_count0", count, 32'd0);
        grad_in_valid = 1'b0;
        tick();
        chk("t3_drained", grad_out_valid, 32'd0);
        chk("t3_back_rec", fwd_ready, 32'd1);

        // 4. errors
        chk("t4_err_before", err, 32'd0);
        start();
        chk("t4_err_empty_start", err, 32'd1);
        chk("t4_stay_rec", fwd_ready, 32'd1);
        do_reset();
        chk("t4_err_cleared", err, 32'd0);
        push(8'h33); start();
        fwd_valid = 1'b1; fwd_mask = 8'hEE;
        tick();
        fwd_valid = 1'b0;
        chk("t4_err_replay_fwd", err, 32'd1);
        chk("t4_count_unchanged", count, 32'd1);
        grad_in_valid = 1'b1; grad_in = 8'h0F;
        tick();
        chk("t4_out", grad_out, 32'h03);
        grad_in_valid = 1'b0;
        tick();

        // 5. simultaneous push/start and enable
        do_reset();
        fwd_valid = 1'b1; fwd_mask = 8'hC3; bwd_start = 1'b1;
        tick();
        fwd_valid = 1'b0; bwd_start = 1'b0;
        chk("t5_count1", count, 32'd1);
        chk("t5_replay", fwd_ready, 32'd0);
        chk("t5_err", err, 32'd0);
        ui_ena = 1'b0; grad_in_valid = 1'b1; grad_in = 8'hAA; grad_out_ready = 1'b1;
        #1;
        chk("t5_ena0_ready", grad_in_ready, 32'd0);
        tick();
        chk("t5_ena0_count", count, 32'd1);
        chk("t5_ena0_gov", grad_out_valid, 32'd0);
        ui_ena = 1'b1;
        tick();
        chk("t5_out", grad_out, 32'h82);
        chk("t5_count0", count, 32'd0);
        grad_in_valid = 1'b0;
        tick();

        // 6. reset mid-replay
        push(8'h11); push(8'h22); push(8'h44); start();
        grad_in_valid = 1'b1; grad_in = 8'hFF; grad_out_ready = 1'b0;
        tick();
        grad_in_valid = 1'b0;
        chk("t6_pre_count", count, 32'd2);
        chk("t6_pre_gov", grad_out_valid, 32'd1);
        chk("t6_pre_out", grad_out, 32'h44);
        rst_n = 1'b0;
        #1;
        chk("t6_count", count, 32'd0);
        chk("t6_gov", grad_out_valid, 32'd0);
        chk("t6_rec", fwd_ready, 32'd1);
        chk("t6_gin_ready", grad_in_ready, 32'd0);
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
